// File: rtl/rgb_byte_packer.sv
// -----------------------------------------------------------------------------
// rgb_byte_packer
//
// Captures Q8.8 RGB pixels from the YCbCr-to-RGB converter, rounds each
// channel to the nearest 8-bit value (round half up, saturating at 8'hFF),
// stores the packed pixel in a small FIFO and emits it as a byte stream
// R, G, B over a valid/ready handshake.
//
// Parameters:
//   DEPTH      FIFO capacity in pixels (power of two, >= 2)
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous active-high reset, clears all state
//   in_valid   R/G/B carry a new pixel this cycle (no backpressure upstream)
//   R, G, B    16-bit unsigned Q8.8 channel values
//   out_data   current output byte (8'h00 while the FIFO is empty)
//   out_valid  out_data is valid (FIFO not empty)
//   out_ready  sink accepts the byte on an edge where out_valid is high
//   overflow   sticky; a pixel was dropped because the FIFO was full
//   level      pixels stored, including one that is partially sent
// -----------------------------------------------------------------------------
module rgb_byte_packer #(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    input  logic [15:0]                R,
    input  logic [15:0]                G,
    input  logic [15:0]                B,
    output logic [7:0]                 out_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic                       overflow,
    output logic [$clog2(DEPTH):0]     level
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    // ------------------------------------------------------------------
    // Per-channel rounding and saturation
    // ------------------------------------------------------------------
    logic [15:0] w_chan_in   [3];
    logic [7:0]  w_chan_byte [3];

    assign w_chan_in[0] = R;
    assign w_chan_in[1] = G;
    assign w_chan_in[2] = B;

    for (genvar gi = 0; gi < 3; gi++) begin : g_round
        logic [16:0] w_sum;
        // Adding half an LSB of the integer part rounds half up; a carry
        // into bit 16 means the rounded value no longer fits in a byte.
        assign w_sum           = {1'b0, w_chan_in[gi]} + 17'h00080;
        assign w_chan_byte[gi] = w_sum[16] ? 8'hFF : w_sum[15:8];
    end

    logic [23:0] w_pixel;
    assign w_pixel = {w_chan_byte[0], w_chan_byte[1], w_chan_byte[2]};

    // ------------------------------------------------------------------
    // FIFO state
    // ------------------------------------------------------------------
    logic [23:0]   r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic [1:0]    r_idx;
    logic          r_overflow;

    logic w_xfer;
    logic w_pop;
    logic w_full;
    logic w_wr;

    assign out_valid = (r_count != '0);
    assign w_xfer    = out_valid && out_ready;
    assign w_pop     = w_xfer && (r_idx == 2'd2);
    assign w_full    = (r_count == FULL_COUNT);
    // A full FIFO still accepts a pixel when the head is popped on the same edge.
    assign w_wr      = in_valid && (!w_full || w_pop);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (w_wr) begin
            r_mem[r_wr_ptr] <= w_pixel;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_count    <= '0;
            r_idx      <= 2'd0;
            r_overflow <= 1'b0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
            if (w_xfer) begin
                r_idx <= (r_idx == 2'd2) ? 2'd0 : r_idx + 2'd1;
            end
            if (in_valid && !w_wr) begin
                r_overflow <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Output byte selection from the head entry
    // ------------------------------------------------------------------
    logic [23:0] w_head;
    assign w_head = r_mem[r_rd_ptr];

    always_comb begin
        out_data = 8'h00;
        if (out_valid) begin
            case (r_idx)
                2'd0:    out_data = w_head[23:16];
                2'd1:    out_data = w_head[15:8];
                2'd2:    out_data = w_head[7:0];
                default: out_data = 8'h00;
            endcase
        end
    end

    assign overflow = r_overflow;
    assign level    = r_count;

endmodule
